// File: rtl/csr_access_ctrl.sv
// csr_access_ctrl: arbitrates core/debug CSR requests and sequences read-modify-write accesses to the CSR file.
module csr_access_ctrl #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              core_req_valid,
    output logic              core_req_ready,
    input  logic [1:0]        core_req_op,
    input  logic [ADDR_W-1:0] core_req_addr,
    input  logic [DATA_W-1:0] core_req_wdata,
    output logic              core_rsp_valid,
    output logic [DATA_W-1:0] core_rsp_rdata,
    output logic              core_rsp_err,
    input  logic              dbg_req_valid,
    output logic              dbg_req_ready,
    input  logic              dbg_req_write,
    input  logic [ADDR_W-1:0] dbg_req_addr,
    input  logic [DATA_W-1:0] dbg_req_wdata,
    output logic              dbg_rsp_valid,
    output logic [DATA_W-1:0] dbg_rsp_rdata,
    output logic              dbg_rsp_err,
    output logic              csr_w_enable,
    output logic [ADDR_W-1:0] csr_addr,
    output logic [DATA_W-1:0] csr_wdata,
    input  logic [DATA_W-1:0] csr_rdata
);
    localparam logic [1:0] OP_RW = 2'b00, OP_RS = 2'b01, OP_RO = 2'b11;
    typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;
    state_t state, state_nx;
    logic last_dbg, src_dbg, err, core_err_q, dbg_err_q;
    logic grant_core, take, do_write, ro_addr;
    logic [1:0] op;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata, old, new_val, core_rd_q, dbg_rd_q;
    always_comb begin
        grant_core     = core_req_valid && (!dbg_req_valid || last_dbg);
        core_req_ready = rst && state == IDLE && grant_core;
        dbg_req_ready  = rst && state == IDLE && dbg_req_valid && !grant_core;
        take           = core_req_ready || dbg_req_ready;
        do_write       = op == OP_RW || (op != OP_RO && wdata != '0);
        ro_addr        = addr[ADDR_W-1 -: 2] == 2'b11;
        new_val        = op == OP_RW ? wdata : op == OP_RS ? (old | wdata) : (old & ~wdata);
        state_nx       = state == IDLE  ? (take ? READ : IDLE) :
                         state == READ  ? ((do_write && !ro_addr) ? WRITE : RESP) :
                         state == WRITE ? RESP : IDLE;
        core_rsp_valid = state == RESP && !src_dbg;
        dbg_rsp_valid  = state == RESP && src_dbg;
        core_rsp_rdata = core_rsp_valid ? old : core_rd_q;
        core_rsp_err   = core_rsp_valid ? err : core_err_q;
        dbg_rsp_rdata  = dbg_rsp_valid ? old : dbg_rd_q;
        dbg_rsp_err    = dbg_rsp_valid ? err : dbg_err_q;
        csr_w_enable   = state == WRITE;
        csr_addr       = (state == READ || state == WRITE) ? addr : '0;
        csr_wdata      = state == WRITE ? new_val : '0;
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            last_dbg   <= 1'b1;
            src_dbg    <= 1'b0;
            op         <= '0;
            addr       <= '0;
            wdata      <= '0;
            old        <= '0;
            err        <= 1'b0;
            core_rd_q  <= '0;
            core_err_q <= 1'b0;
            dbg_rd_q   <= '0;
            dbg_err_q  <= 1'b0;
        end else begin
            state <= state_nx;
            if (take) begin
                src_dbg  <= !grant_core;
                last_dbg <= !grant_core;
                op       <= grant_core ? core_req_op : (dbg_req_write ? OP_RW : OP_RO);
                addr     <= grant_core ? core_req_addr : dbg_req_addr;
                wdata    <= grant_core ? core_req_wdata : dbg_req_wdata;
            end
            if (state == READ) begin
                old <= csr_rdata;
                err <= do_write && ro_addr;
            end
            if (core_rsp_valid) begin
                core_rd_q  <= old;
                core_err_q <= err;
            end
            if (dbg_rsp_valid) begin
                dbg_rd_q  <= old;
                dbg_err_q <= err;
            end
        end
    end
endmodule
